// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read side: widths, index/data
// types and the write-vector legality checks used by every block.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int IDX_W  = $clog2(NREG);

   typedef logic [IDX_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   // Bit 0 of the write vector targets the hardwired zero register and is
   // ignored, so legality looks only at bits NREG-1..1.
   function automatic logic is_legal_write(input logic [NREG-1:0] we);
      return $countones(we[NREG-1:1]) == 1;
   endfunction

   function automatic logic is_multi_write(input logic [NREG-1:0] we);
      return $countones(we[NREG-1:1]) > 1;
   endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One read port: selects a stored register, bypasses a same-cycle legal write
// to that register, and forces register 0 to read as zero.
module regfile_read_mux #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic [$clog2(NREG)-1:0] index,
   input  logic [DATA_W-1:0]       storage [NREG],
   input  logic                    write_legal,
   input  logic [NREG-1:0]         write_en,
   input  logic [DATA_W-1:0]       write_data,
   output logic [DATA_W-1:0]       data,
   output logic                    write_hit
);
   import regfile_pkg::*;

   assign write_hit = write_legal && (index != REG_ZERO) && write_en[index];

   always_comb begin
      if (index == REG_ZERO) begin
         data = '0;
      end else if (write_hit) begin
         data = write_data;
      end else begin
         data = storage[index];
      end
   end

endmodule

// File: rtl/regfile_read_unit.sv
// Register file read unit: storage for r1..r31, pending-write scoreboard that
// gates issue, and two registered operand ports with same-cycle write bypass.
module regfile_read_unit #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREG-1:0]         WriteEn,
   input  logic [DATA_W-1:0]       WriteData,
   input  logic                    IssueValid,
   input  logic [$clog2(NREG)-1:0] ReadReg1,
   input  logic [$clog2(NREG)-1:0] ReadReg2,
   input  logic [$clog2(NREG)-1:0] IssueDst,
   input  logic                    IssueDstValid,
   output logic                    IssueReady,
   output logic                    ReadValid,
   output logic [DATA_W-1:0]       ReadData1,
   output logic [DATA_W-1:0]       ReadData2,
   output logic [NREG-1:0]         PendingMask,
   output logic                    OneHotErr
);
   import regfile_pkg::*;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_next;
   logic              write_legal;
   logic              write_multi;
   logic [DATA_W-1:0] port1_data;
   logic [DATA_W-1:0] port2_data;
   logic              port1_hit;
   logic              port2_hit;
   logic              hazard1;
   logic              hazard2;
   logic              accept;

   assign write_legal = is_legal_write(WriteEn);
   assign write_multi = is_multi_write(WriteEn);

   regfile_read_mux #(.DATA_W(DATA_W), .NREG(NREG)) u_port1 (
      .index      (ReadReg1),
      .storage    (regs),
      .write_legal(write_legal),
      .write_en   (WriteEn),
      .write_data (WriteData),
      .data       (port1_data),
      .write_hit  (port1_hit)
   );

   regfile_read_mux #(.DATA_W(DATA_W), .NREG(NREG)) u_port2 (
      .index      (ReadReg2),
      .storage    (regs),
      .write_legal(write_legal),
      .write_en   (WriteEn),
      .write_data (WriteData),
      .data       (port2_data),
      .write_hit  (port2_hit)
   );

   // A source waiting on writeback stops stalling in the cycle its write lands.
   assign hazard1    = (ReadReg1 != REG_ZERO) && pending[ReadReg1] && !port1_hit;
   assign hazard2    = (ReadReg2 != REG_ZERO) && pending[ReadReg2] && !port2_hit;
   assign IssueReady = !hazard1 && !hazard2;
   assign accept     = IssueValid && IssueReady;

   // NOTE: every always_comb output gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      pending_next = pending;
      if (write_legal) begin
         pending_next = pending_next & ~WriteEn;
      end
      if (accept && IssueDstValid && (IssueDst != REG_ZERO)) begin
         pending_next[IssueDst] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   // NOTE: this storage array is reset on purpose because architectural
   // registers must read 0 after reset; plain RAMs normally are not reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (write_legal) begin
         for (int i = 1; i < NREG; i++) begin
            if (WriteEn[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         ReadValid <= 1'b0;
         ReadData1 <= '0;
         ReadData2 <= '0;
         OneHotErr <= 1'b0;
      end else begin
         pending   <= pending_next;
         ReadValid <= accept;
         if (accept) begin
            ReadData1 <= port1_data;
            ReadData2 <= port2_data;
         end
         if (write_multi) begin
            OneHotErr <= 1'b1;
         end
      end
   end

   assign PendingMask = pending;

endmodule
